// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC and the Start/Ack run handshake,
// redirects on Ctrl branches and keeps saturating run/branch counters.
module fetch_sequencer #(
  parameter int                PC_W      = 10,
  parameter int                IW        = 9,
  parameter logic [IW-1:0]     IDLE_INST = 9'h1FF,
  parameter int                CNT_W     = 16,
  parameter logic [PC_W-1:0]   START_PC  = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [IW-1:0]    InstIn,
  input  logic             BranchAbsEn,
  input  logic             BranchRelEn,
  input  logic             Flag,
  input  logic [PC_W-1:0]  Target,
  input  logic             HaltReq,
  output logic [PC_W-1:0]  InstAddr,
  output logic [IW-1:0]    ActiveInst,
  output logic             Running,
  output logic             Ack,
  output logic [CNT_W-1:0] CycleCount,
  output logic [CNT_W-1:0] BranchCount
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN,
    DONE
  } state_t;

  localparam logic [PC_W-1:0]  PcOne  = 1;
  localparam logic [CNT_W-1:0] CntOne = 1;

  state_t           state, stateNxt;
  logic [PC_W-1:0]  pc, pcNxt;
  logic             ack, ackNxt;
  logic [CNT_W-1:0] cycCnt, cycNxt;
  logic [CNT_W-1:0] brCnt, brNxt;

  logic             takeAbs, takeRel;
  logic [CNT_W-1:0] cycInc, brInc;

  assign takeAbs = BranchAbsEn;
  assign takeRel = !BranchAbsEn && BranchRelEn && Flag;
  assign cycInc  = (&cycCnt) ? cycCnt : cycCnt + CntOne;
  assign brInc   = (&brCnt) ? brCnt : brCnt + CntOne;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      pc     <= START_PC;
      ack    <= 1'b0;
      cycCnt <= '0;
      brCnt  <= '0;
    end else begin
      state  <= stateNxt;
      pc     <= pcNxt;
      ack    <= ackNxt;
      cycCnt <= cycNxt;
      brCnt  <= brNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    pcNxt    = pc;
    ackNxt   = ack;
    cycNxt   = cycCnt;
    brNxt    = brCnt;
    // Start from any state re-arms, so ARMED always shows START_PC.
    if (Start) begin
      stateNxt = ARMED;
      pcNxt    = START_PC;
      ackNxt   = 1'b0;
      cycNxt   = '0;
      brNxt    = '0;
    end else begin
      unique case (state)
        IDLE: begin
        end
        ARMED: begin
          stateNxt = RUN;
          pcNxt    = START_PC;
          ackNxt   = 1'b0;
          cycNxt   = '0;
          brNxt    = '0;
        end
        RUN: begin
          cycNxt = cycInc;
          if (HaltReq) begin
            stateNxt = DONE;
            ackNxt   = 1'b1;
          end else begin
            unique case (1'b1)
              takeAbs: begin
                pcNxt = Target;
                brNxt = brInc;
              end
              takeRel: begin
                pcNxt = pc + Target;
                brNxt = brInc;
              end
              default: pcNxt = pc + PcOne;
            endcase
          end
        end
        DONE: begin
        end
      endcase
    end
  end

  assign Running     = (state == RUN);
  assign ActiveInst  = Running ? InstIn : IDLE_INST;
  assign InstAddr    = pc;
  assign Ack         = ack;
  assign CycleCount  = cycCnt;
  assign BranchCount = brCnt;

endmodule
